// File: rtl/mole_sched.sv
// Whack-a-mole round scheduler: gap, random hole pick, timed mole window, scoring.
// WRONG_KEY_PENALTY_EN: wrong key in UP costs one point and pulses miss.
module mole_sched #(
  parameter int GAP_TICKS = 25_000_000,
  parameter int UP_TICKS  = 50_000_000,
  parameter int ROUNDS    = 16,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         rnd,
  input  logic               start,
  input  logic [3:0]         key,
  output logic [3:0]         mole,
  output logic               hit,
  output logic               miss,
  output logic [SCORE_W-1:0] score,
  output logic               done,
  output logic               busy
);

  localparam int MAXT  = (GAP_TICKS > UP_TICKS) ? GAP_TICKS : UP_TICKS;
  localparam int CNT_W = $clog2(MAXT + 1);
  localparam int RND_W = $clog2(ROUNDS + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] UP_LAST  = CNT_W'(UP_TICKS - 1);
  localparam logic [RND_W-1:0] ROUND_N  = RND_W'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    UP,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RND_W-1:0]   rcnt_q, rcnt_d;
  logic [RND_W-1:0]   rcnt_inc;
  logic [1:0]         prev_q, prev_d;
  logic [1:0]         pick;
  logic [3:0]         mole_d;
  logic               hit_d, miss_d;
  logic [SCORE_W-1:0] score_d, score_inc;
  logic               done_d, busy_d;
  logic               key_hit, tmo, gap_end;
  logic               unused_rnd;

  assign unused_rnd = ^rnd[3:2];

  // Never show the same hole twice in a row
  assign pick      = (rnd[1:0] == prev_q) ? rnd[1:0] + 2'd1 : rnd[1:0];
  assign key_hit   = key[prev_q];
  assign tmo       = (cnt_q == UP_LAST);
  assign gap_end   = (cnt_q == GAP_LAST);
  assign rcnt_inc  = rcnt_q + 1'b1;
  assign score_inc = (&score) ? score : score + 1'b1;

`ifdef WRONG_KEY_PENALTY_EN
  logic               key_bad;
  logic [SCORE_W-1:0] score_dec;
  assign key_bad   = |(key & ~(4'b0001 << prev_q));
  assign score_dec = (score == '0) ? score : score - 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = GAP;
      GAP:  if (gap_end) state_d = UP;
      UP: begin
        if (key_hit || tmo)
          state_d = (rcnt_inc == ROUND_N) ? DONE : GAP;
      end
      DONE: if (start) state_d = GAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    rcnt_d  = rcnt_q;
    prev_d  = prev_q;
    mole_d  = mole;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    score_d = score;
    unique case (state_q)
      IDLE, DONE: begin
        cnt_d = '0;
        if (start) begin
          score_d = '0;
          rcnt_d  = '0;
        end
      end
      GAP: begin
        if (gap_end) begin
          cnt_d  = '0;
          prev_d = pick;
          mole_d = 4'b0001 << pick;
        end
      end
      UP: begin
        // A hit on the timeout cycle still counts as a hit
        if (key_hit || tmo) begin
          cnt_d  = '0;
          mole_d = '0;
          rcnt_d = rcnt_inc;
          hit_d  = key_hit;
          miss_d = ~key_hit;
          if (key_hit) score_d = score_inc;
        end
`ifdef WRONG_KEY_PENALTY_EN
        else if (key_bad) begin
          miss_d  = 1'b1;
          score_d = score_dec;
        end
`endif
      end
      default: cnt_d = '0;
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d == GAP) || (state_d == UP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rcnt_q <= '0;
      prev_q <= '0;
      mole   <= '0;
      hit    <= 1'b0;
      miss   <= 1'b0;
      score  <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rcnt_q <= rcnt_d;
      prev_q <= prev_d;
      mole   <= mole_d;
      hit    <= hit_d;
      miss   <= miss_d;
      score  <= score_d;
      done   <= done_d;
      busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_mole_sched.sv
// Scoreboard bench for mole_sched with GAP_TICKS=5, UP_TICKS=10, ROUNDS=3.
// Stimulus pushes expected hit/miss/mole-rise events; a negedge monitor checks them.
module tb_mole_sched;

`ifdef WRONG_KEY_PENALTY_EN
  localparam int PEN = 1;
`else
  localparam int PEN = 0;
`endif

  typedef struct {
    int         cyc;
    logic       hit;
    logic       miss;
    logic [3:0] mole;
    logic [7:0] score;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rnd = 4'b0;
  logic       start = 1'b0;
  logic [3:0] key = 4'b0;
  logic [3:0] mole;
  logic       hit, miss, done, busy;
  logic [7:0] score;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  ev_t  sb[$];
  logic [3:0] mole_prev = 4'b0;

  mole_sched #(
    .GAP_TICKS(5),
    .UP_TICKS(10),
    .ROUNDS(3),
    .SCORE_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rnd(rnd),
    .start(start),
    .key(key),
    .mole(mole),
    .hit(hit),
    .miss(miss),
    .score(score),
    .done(done),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic h, input logic m,
                      input logic [3:0] mo, input int sc);
    ev_t e;
    e.cyc = c;
    e.hit = h;
    e.miss = m;
    e.mole = mo;
    e.score = 8'(sc);
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic pulse_start(input int n);
    wait_cyc(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_key(input int n, input logic [3:0] k);
    wait_cyc(n);
    key = k;
    @(negedge clk);
    key = 4'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && (hit || miss || (mole != 4'b0 && mole != mole_prev))) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected event: cyc=%0d hit=%0b miss=%0b mole=%b score=%0d",
                 cyc, hit, miss, mole, score);
      end else begin
        ev_t e;
        e = sb.pop_front();
        if (e.cyc != cyc || e.hit !== hit || e.miss !== miss ||
            e.mole !== mole || e.score !== score) begin
          bad++;
          $display("FAIL event: got cyc=%0d hit=%0b miss=%0b mole=%b score=%0d want cyc=%0d hit=%0b miss=%0b mole=%b score=%0d",
                   cyc, hit, miss, mole, score,
                   e.cyc, e.hit, e.miss, e.mole, e.score);
        end
      end
    end
    mole_prev = mole;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    wait_cyc(1);
    chk("rst_mole", 32'(mole), 0);
    chk("rst_hit", 32'(hit), 0);
    chk("rst_miss", 32'(miss), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    wait_cyc(2);
    rst_n = 1'b1;

    // Game 1: timeout, bumped hit, wrap + hit on timeout cycle
    rnd = 4'b0110;
    push(11, 0, 0, 4'b0100, 0);
    push(21, 0, 1, 4'b0000, 0);
    push(26, 0, 0, 4'b1000, 0);
    push(29, 1, 0, 4'b0000, 1);
    push(34, 0, 0, 4'b0001, 1);
    if (PEN != 0) push(37, 0, 1, 4'b0001, 0);
    push(44, 1, 0, 4'b0000, 2 - PEN);
    pulse_start(5);
    pulse_key(7, 4'b0100);
    pulse_start(8);
    wait_cyc(12);
    chk("g1_mole", 32'(mole), 32'b0100);
    chk("g1_busy", 32'(busy), 1);
    wait_cyc(15);
    rnd = 4'b1010;
    pulse_key(28, 4'b1000);
    rnd = 4'b0011;
    pulse_key(36, 4'b0010);
    pulse_key(43, 4'b0001);
    wait_cyc(46);
    chk("done_done", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_score", 32'(score), 32'(2 - PEN));
    chk("done_mole", 32'(mole), 0);

    // Game 2: restart from DONE, then reset while mole is up
    rnd = 4'b0110;
    push(54, 0, 0, 4'b0100, 0);
    push(57, 1, 0, 4'b0000, 1);
    push(62, 0, 0, 4'b1000, 1);
    pulse_start(48);
    chk("rs_score", 32'(score), 0);
    chk("rs_done", 32'(done), 0);
    chk("rs_busy", 32'(busy), 1);
    pulse_key(56, 4'b0100);
    rnd = 4'b1010;
    wait_cyc(64);
    rst_n = 1'b0;
    #1;
    chk("arst_mole", 32'(mole), 0);
    chk("arst_score", 32'(score), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    wait_cyc(66);
    rst_n = 1'b1;

    // Game 3: rnd=0 with previous hole 0 after reset
    rnd = 4'b0000;
    push(74, 0, 0, 4'b0010, 0);
    push(76, 1, 0, 4'b0000, 1);
    push(81, 0, 0, 4'b0100, 1);
    pulse_start(68);
    pulse_key(75, 4'b0010);
    rnd = 4'b0101;
    wait_cyc(84);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
